// File: rtl/seq_alu.sv
// Registered accumulator ALU with a start/busy/done handshake. It adds SUB, a
// shift-add multiplier and a rotate-through-carry by N to the accumulator ops.
module seq_alu #(
  parameter int WIDTH      = 16,
  parameter int INPR_WIDTH = 8,
  parameter int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [3:0]            op_in,
  input  logic [WIDTH-1:0]      ac_in,
  input  logic [WIDTH-1:0]      dr_in,
  input  logic [INPR_WIDTH-1:0] inpr_in,
  input  logic                  c_in,
  output logic [WIDTH-1:0]      ac_out,
  output logic                  c_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);
  // Handshake: a request is taken on any rising edge where start_in=1 and the
  // FSM is IDLE. done_out/err_out pulse for exactly one cycle per operation.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_ROT = 2'd2} state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LDDR = 4'd2;
  localparam logic [3:0] OP_INP  = 4'd3;
  localparam logic [3:0] OP_CMA  = 4'd4;
  localparam logic [3:0] OP_CIR  = 4'd5;
  localparam logic [3:0] OP_CIL  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_RORN = 4'd9;

  state_t             r_state, w_state_nxt;
  logic [2*WIDTH-1:0] r_mcand, r_prod, w_prod_add;
  logic [WIDTH-1:0]   r_mplier, r_ac, w_ac_nxt, w_alu_ac, w_inpr_ext;
  logic [WIDTH:0]     r_ring, w_ring_rot, w_add, w_sub;
  logic [CNT_W-1:0]   r_cnt, w_k;
  logic               r_c, r_busy, r_done, r_err;
  logic               w_c_nxt, w_done_nxt, w_err_nxt, w_alu_c, w_alu_err;
  logic               w_accept, w_multi, w_last;

  assign w_k        = dr_in[CNT_W-1:0];
  assign w_accept   = (r_state == S_IDLE) && start_in;
  assign w_multi    = (op_in == OP_MUL) || ((op_in == OP_RORN) && (w_k != '0));
  assign w_last     = (r_cnt == CNT_W'(1));
  assign w_prod_add = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_ring_rot = {r_ring[0], r_ring[WIDTH:1]};
  assign w_add      = {1'b0, ac_in} + {1'b0, dr_in};
  assign w_sub      = {1'b0, ac_in} + {1'b0, ~dr_in} + (WIDTH+1)'(1);

  always_comb begin
    w_inpr_ext = '0;
    w_inpr_ext[INPR_WIDTH-1:0] = inpr_in;
  end

  // Single-cycle results, computed straight from the request inputs.
  always_comb begin
    w_alu_ac  = '0;
    w_alu_c   = 1'b0;
    w_alu_err = 1'b0;
    case (op_in)
      OP_AND:  w_alu_ac = ac_in & dr_in;
      OP_ADD:  {w_alu_c, w_alu_ac} = w_add;
      OP_LDDR: w_alu_ac = dr_in;
      OP_INP:  w_alu_ac = w_inpr_ext;
      OP_CMA:  w_alu_ac = ~ac_in;
      OP_CIR:  {w_alu_ac, w_alu_c} = {c_in, ac_in};
      OP_CIL:  {w_alu_c, w_alu_ac} = {ac_in, c_in};
      OP_SUB:  {w_alu_c, w_alu_ac} = w_sub;
      OP_MUL:  w_alu_ac = '0;
      OP_RORN: {w_alu_c, w_alu_ac} = {c_in, ac_in};
      default: w_alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_in && w_multi) w_state_nxt = (op_in == OP_MUL) ? S_MUL : S_ROT;
      S_MUL:  if (w_last) w_state_nxt = S_IDLE;
      S_ROT:  if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ac_nxt   = r_ac;
    w_c_nxt    = r_c;
    w_done_nxt = 1'b0;
    w_err_nxt  = 1'b0;
    case (r_state)
      S_IDLE: if (start_in && !w_multi) begin
        w_done_nxt = 1'b1;
        w_err_nxt  = w_alu_err;
        if (!w_alu_err) begin
          w_ac_nxt = w_alu_ac;
          w_c_nxt  = w_alu_c;
        end
      end
      S_MUL: if (w_last) begin
        w_done_nxt = 1'b1;
        w_ac_nxt   = w_prod_add[WIDTH-1:0];
        w_c_nxt    = |w_prod_add[2*WIDTH-1:WIDTH];
      end
      S_ROT: if (w_last) begin
        w_done_nxt = 1'b1;
        w_ac_nxt   = w_ring_rot[WIDTH-1:0];
        w_c_nxt    = w_ring_rot[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_ac   <= '0;
      r_c    <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ac   <= w_ac_nxt;
      r_c    <= w_c_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Working registers; the multiplicand is kept double-width so no product bit is lost.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_ring   <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, ac_in};
      r_mplier <= dr_in;
      r_prod   <= '0;
      r_ring   <= {c_in, ac_in};
      r_cnt    <= (op_in == OP_MUL) ? CNT_W'(WIDTH) : w_k;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_add;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end else if (r_state == S_ROT) begin
      r_ring   <= w_ring_rot;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

  assign ac_out   = r_ac;
  assign c_out    = r_c;
  assign busy_out = r_busy;
  assign done_out = r_done;
  assign err_out  = r_err;
endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu: expected results are queued at issue
// and compared, with their completion cycle, when done_out pulses.
module tb_seq_alu;
  localparam int W  = 16;
  localparam int IW = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk_in = 1'b0;
  logic          reset_in, start_in, c_in;
  logic [3:0]    op_in;
  logic [W-1:0]  ac_in, dr_in;
  logic [IW-1:0] inpr_in;
  logic [W-1:0]  ac_out;
  logic          c_out, busy_out, done_out, err_out;

  typedef struct packed {
    logic [W-1:0] ac;
    logic         c;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         exp_q[$];
  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  logic [W-1:0] last_ac = '0;
  logic         last_c  = 1'b0;

  seq_alu #(.WIDTH(W), .INPR_WIDTH(IW)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .start_in (start_in),
    .op_in    (op_in),
    .ac_in    (ac_in),
    .dr_in    (dr_in),
    .inpr_in  (inpr_in),
    .c_in     (c_in),
    .ac_out   (ac_out),
    .c_out    (c_out),
    .busy_out (busy_out),
    .done_out (done_out),
    .err_out  (err_out)
  );

  // clock/reset block
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score any completion seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk_in);
    if (done_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done_out), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result_ac", 32'(ac_out), 32'(e.ac));
        chk("result_c", 32'(c_out), 32'(e.c));
        chk("result_err", 32'(err_out), 32'(e.err));
        chk("done_cycle", cyc, e.cyc);
      end
    end else begin
      chk("err_without_done", 32'(err_out), 32'd0);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d,
                       input logic [IW-1:0] p, input logic ci, input logic [W-1:0] ea,
                       input logic ec, input logic ee, input int lat);
    exp_t e;
    op_in = op; ac_in = a; dr_in = d; inpr_in = p; c_in = ci; start_in = 1'b1;
    e.ac = ea; e.c = ec; e.err = ee; e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    if (!ee) begin
      last_ac = ea;
      last_c  = ec;
    end
    tick();
    start_in = 1'b0;
    op_in    = 4'($urandom);
    ac_in    = W'($urandom);
    dr_in    = W'($urandom);
    inpr_in  = IW'($urandom);
    c_in     = 1'($urandom);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] d,
                                input logic [IW-1:0] p, input logic ci, output logic [W-1:0] ra,
                                output logic rc, output logic re, output int lat);
    logic [W:0]     t;
    logic [2*W-1:0] pr;
    int             k;
    ra = last_ac; rc = last_c; re = 1'b0; lat = 0;
    case (op)
      4'd0: begin ra = a & d; rc = 1'b0; end
      4'd1: begin t = {1'b0, a} + {1'b0, d}; ra = t[W-1:0]; rc = t[W]; end
      4'd2: begin ra = d; rc = 1'b0; end
      4'd3: begin ra = W'(p); rc = 1'b0; end
      4'd4: begin ra = ~a; rc = 1'b0; end
      4'd5: begin ra = {ci, a[W-1:1]}; rc = a[0]; end
      4'd6: begin ra = {a[W-2:0], ci}; rc = a[W-1]; end
      4'd7: begin t = {1'b0, a} - {1'b0, d}; ra = t[W-1:0]; rc = (a >= d); end
      4'd8: begin
        pr = (2*W)'(a) * (2*W)'(d);
        ra = pr[W-1:0]; rc = |pr[2*W-1:W]; lat = W;
      end
      4'd9: begin
        k = int'(d[CW-1:0]);
        t = {ci, a};
        for (int i = 0; i < k; i++) t = {t[0], t[W:1]};
        ra = t[W-1:0]; rc = t[W]; lat = k;
      end
      default: re = 1'b1;
    endcase
  endfunction

  initial begin
    logic [3:0]    r_op;
    logic [W-1:0]  r_a, r_d, m_ac;
    logic [IW-1:0] r_p;
    logic          r_ci, m_c, m_e;
    int            m_lat;

    reset_in = 1'b1; start_in = 1'b0; op_in = '0; ac_in = '0; dr_in = '0;
    inpr_in = '0; c_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_ac", 32'(ac_out), 32'd0);
    chk("reset_c", 32'(c_out), 32'd0);
    chk("reset_busy", 32'(busy_out), 32'd0);
    chk("reset_done", 32'(done_out), 32'd0);
    chk("reset_err", 32'(err_out), 32'd0);
    reset_in = 1'b0;
    @(negedge clk_in);

    // ADD/SUB carry behaviour, all single-cycle
    issue(4'd1, 16'hFFFF, 16'h0001, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    chk("add_busy", 32'(busy_out), 32'd0);
    issue(4'd7, 16'h0005, 16'h0007, 8'h00, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0);
    chk("sub_borrow_busy", 32'(busy_out), 32'd0);
    issue(4'd7, 16'h0007, 16'h0005, 8'h00, 1'b0, 16'h0002, 1'b1, 1'b0, 0);
    chk("sub_busy", 32'(busy_out), 32'd0);
    drain(4);

    // Reset in the middle of a multiply
    op_in = 4'd8; ac_in = 16'h1234; dr_in = 16'h0010; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("mul_busy_pre_reset", 32'(busy_out), 32'd1);
    reset_in = 1'b1;
    #1;
    chk("midreset_ac", 32'(ac_out), 32'd0);
    chk("midreset_c", 32'(c_out), 32'd0);
    chk("midreset_busy", 32'(busy_out), 32'd0);
    chk("midreset_done", 32'(done_out), 32'd0);
    chk("midreset_err", 32'(err_out), 32'd0);
    @(negedge clk_in);
    reset_in = 1'b0;
    issue(4'd1, 16'h0003, 16'h0004, 8'h00, 1'b0, 16'h0007, 1'b0, 1'b0, 0);
    drain(4);
    tick();
    chk("single_done_pulse", 32'(done_out), 32'd0);

    // Multiply timing, busy window and ignored starts
    issue(4'd8, 16'h00FF, 16'h0101, 8'h00, 1'b0, 16'hFFFF, 1'b0, 1'b0, W);
    chk("mul_busy_first", 32'(busy_out), 32'd1);
    for (int i = 1; i < W; i++) begin
      op_in = 4'd1; ac_in = 16'h1111; dr_in = 16'h2222; start_in = i[0];
      tick();
      chk("mul_busy_hold", 32'(busy_out), 32'd1);
      chk("mul_out_hold", 32'(ac_out), 32'h0007);
    end
    start_in = 1'b0;
    tick();
    chk("mul_busy_end", 32'(busy_out), 32'd0);
    drain(2);
    issue(4'd8, 16'h1000, 16'h0010, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, W);
    drain(W + 4);

    // Rotate through carry by N
    issue(4'd9, 16'h0001, 16'h0001, 8'h00, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    drain(4);
    issue(4'd9, 16'hBEEF, 16'd17, 8'h00, 1'b1, 16'hBEEF, 1'b1, 1'b0, 17);
    drain(24);
    issue(4'd9, 16'h5A5A, 16'h0020, 8'h00, 1'b0, 16'h5A5A, 1'b0, 1'b0, 0);
    chk("rorn_k0_busy", 32'(busy_out), 32'd0);
    drain(4);

    // Six single-cycle ops back-to-back
    issue(4'd6, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h0002, 1'b1, 1'b0, 0);
    issue(4'd5, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h4000, 1'b1, 1'b0, 0);
    issue(4'd3, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h00A5, 1'b0, 1'b0, 0);
    issue(4'd4, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h7FFE, 1'b0, 1'b0, 0);
    issue(4'd0, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h0000, 1'b0, 1'b0, 0);
    issue(4'd2, 16'h8001, 16'h00F0, 8'hA5, 1'b0, 16'h00F0, 1'b0, 1'b0, 0);
    drain(4);

    // Illegal opcode keeps the previous result
    issue(4'd7, 16'h1235, 16'h0001, 8'h00, 1'b0, 16'h1234, 1'b1, 1'b0, 0);
    issue(4'd12, 16'hFFFF, 16'hFFFF, 8'hFF, 1'b0, 16'h1234, 1'b1, 1'b1, 0);
    drain(4);
    tick();
    chk("illegal_done_clear", 32'(done_out), 32'd0);
    chk("illegal_ac_hold", 32'(ac_out), 32'h1234);

    // Random operations against the reference model
    for (int n = 0; n < 24; n++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = W'($urandom_range(0, 65535));
      r_d   = W'($urandom_range(0, 65535));
      r_p   = IW'($urandom_range(0, 255));
      r_ci  = 1'($urandom_range(0, 1));
      model(r_op, r_a, r_d, r_p, r_ci, m_ac, m_c, m_e, m_lat);
      issue(r_op, r_a, r_d, r_p, r_ci, m_ac, m_c, m_e, m_lat);
      drain(40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the accumulator ALU. Adds a start/busy/done handshake, SUB, a sequential shift-add multiplier, and a multi-cycle rotate-through-carry by N.
- Sits between the AC/E register datapath and the control sequencer. The sequencer issues one operation at a time and waits for done_out.
- Results are held in output registers until the next operation completes.

Parameters:
- WIDTH, 16: data width of AC and DR; must be at least 2.
- INPR_WIDTH, 8: input-register width; must not exceed WIDTH. The value is zero-extended.
- CNT_W, $clog2(WIDTH+1): width of the rotate-count field taken from dr_in.

Ports:
- clk_in  input  1  rising-edge clock
- reset_in  input  1  asynchronous, active-high reset
- start_in  input  1  request; sampled only while busy_out=0
- op_in  input  4  opcode, sampled with start_in
- ac_in  input  WIDTH  AC operand, sampled with start_in
- dr_in  input  WIDTH  DR operand / rotate count, sampled with start_in
- inpr_in  input  INPR_WIDTH  input register, sampled with start_in
- c_in  input  1  carry/E flag, sampled with start_in
- ac_out  output  WIDTH  registered result
- c_out  output  1  registered carry result
- busy_out  output  1  multi-cycle operation in progress
- done_out  output  1  one-cycle completion pulse
- err_out  output  1  one-cycle pulse, coincident with done_out, for an illegal opcode

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - ac_out=0, c_out=0, busy_out=0, done_out=0, err_out=0.
  - FSM goes to IDLE; the partial result is discarded.
- Acceptance: start_in=1 while in IDLE at edge N. Operands are latched at edge N, so later changes to the inputs have no effect.
- Opcodes and results (C means carry out):
  - 0 AND: ac&dr, C=0.
  - 1 ADD: ac+dr modulo 2^WIDTH, C=carry out.
  - 2 LDDR: dr, C=0.
  - 3 INP: zero-extended inpr, C=0.
  - 4 CMA: ~ac, C=0.
  - 5 CIR: {c, ac[W-1:1]}, C=ac[0].
  - 6 CIL: {ac[W-2:0], c}, C=ac[W-1].
  - 7 SUB: ac+~dr+1, C=carry out (1 means no borrow).
  - 8 MUL: low WIDTH bits of unsigned ac*dr, C = OR of the high WIDTH product bits (overflow).
  - 9 RORN: rotate the (WIDTH+1)-bit ring {c, ac} right k times, with k = dr[CNT_W-1:0].
  - 10-15: illegal.
- FSM states: IDLE, MUL, ROT.
- Single-cycle ops (0-7, RORN with k=0, illegal):
  - Result is registered at edge N; done_out=1 for the cycle after edge N.
  - The FSM stays in IDLE; busy_out is never asserted.
  - RORN k=0 leaves ac/c equal to the latched ac_in/c_in.
- MUL:
  - IDLE→MUL at edge N; busy_out=1 from edge N.
  - Shift-add, one multiplier bit per cycle, WIDTH iterations. The final result is registered at edge N+WIDTH, together with busy_out←0, done_out←1, and MUL→IDLE.
  - Double-width internal accumulator; no truncation until the end.
- RORN, k≥1:
  - IDLE→ROT at edge N; one ring step per cycle.
  - Result, busy_out←0 and done_out←1 are all registered at edge N+k.
  - k > WIDTH+1 wraps naturally: k=WIDTH+1 returns the original value.
- Illegal opcode: ac_out and c_out hold their previous values; err_out=1 together with done_out.
- Output registers:
  - ac_out and c_out change only at completion edges.
  - While busy, they hold the previous result; intermediate values are never visible.
- start_in while busy_out=1 is ignored and is not queued.
- Back-to-back operation: start_in may be high in the cycle done_out=1 is high, because the FSM is already in IDLE. It is accepted, giving a throughput of 1 op/cycle for single-cycle ops.
- done_out and err_out are registered pulses that are never asserted for more than one cycle per operation.

Test Plan:
- Reset mid-MUL: start MUL with ac=0x1234, dr=0x0010; assert reset_in at cycle 5 → all outputs 0 immediately. Start ADD next → correct result and a single done pulse.
- ADD/SUB carry (WIDTH=16):
  - ADD 0xFFFF+0x0001 → ac=0x0000, c=1.
  - SUB 0x0005−0x0007 → ac=0xFFFE, c=0.
  - SUB 0x0007−0x0005 → ac=0x0002, c=1.
  - Each has done_out in the cycle after start, with busy_out=0 throughout.
- MUL timing and overflow:
  - 0x00FF*0x0101 → ac=0xFFFF, c=0, done exactly 16 cycles after accept.
  - 0x1000*0x0010 → ac=0x0000, c=1.
  - busy_out is high for those 16 cycles, and start_in pulses during busy are ignored.
- RORN:
  - ac=0x0001, c=0, k=1 → ac=0x0000, c=1 after 1 cycle.
  - k=17 → original value after 17 cycles.
  - k=0 → unchanged, done in 1 cycle.
- CIL/CIR/INP/CMA/AND/LDDR: ac=0x8001, c=0, dr=0x00F0, inpr=0xA5.
  - CIL → 0x0002/c=1.
  - CIR → 0x4000/c=1.
  - INP → 0x00A5.
  - CMA → 0x7FFE.
  - AND → 0x0000.
  - LDDR → 0x00F0.
  - Issue all six back-to-back, one per cycle.
- Illegal opcode 12 after a result of 0x1234/c=1 → done_out=err_out=1 for one cycle; ac_out=0x1234, c_out=1 unchanged.
